multicycle_control: RTL and testbench

- Multicycle sequencer for the MIPS-subset datapath; replaces single-decode `Control` timing with an explicit per-instruction state machine.
- Takes the opcode from the instruction register and emits, one state per cycle, the datapath controls: PCEsc, IREsc, ULAop, MemParaReg, EscMem, LeMem, Desvio, ULAFonte, RegDest, EscReg.
- Adds a data-memory ready handshake with timeout, a run enable, an illegal-opcode trap and a retired-instruction counter.

---
 rtl/multicycle_control.sv | 186 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS-subset sequencer with memory timeout, illegal-opcode trap and retire counter
module multicycle_control #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             habilita,
   input  logic [5:0]       opcode,
   input  logic             mem_pronto,
   output logic             PCEsc,
   output logic             IREsc,
   output logic [1:0]       ULAop,
   output logic             MemParaReg,
   output logic             EscMem,
   output logic             LeMem,
   output logic             Desvio,
   output logic             ULAFonte,
   output logic             RegDest,
   output logic             EscReg,
   output logic [2:0]       estado,
   output logic             erro,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [2:0] {
      BUSCA      = 3'd0,
      DECODIFICA = 3'd1,
      EXECUTA    = 3'd2,
      MEMORIA    = 3'd3,
      ESCRITA    = 3'd4,
      ERRO       = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      CL_NONE = 3'd0,
      CL_R    = 3'd1,
      CL_LW   = 3'd2,
      CL_SW   = 3'd3,
      CL_BEQ  = 3'd4,
      CL_ADDI = 3'd5
   } class_t;

   localparam logic [7:0]       TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state;
   class_t           op_class;
   class_t           dec_class;
   logic [7:0]       wait_cnt;
   logic [CNT_W-1:0] count;

   always_comb begin
      case (opcode)
         6'b000000: dec_class = CL_R;
         6'b100011: dec_class = CL_LW;
         6'b101011: dec_class = CL_SW;
         6'b000100: dec_class = CL_BEQ;
         6'b001000: dec_class = CL_ADDI;
         default:   dec_class = CL_NONE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= BUSCA;
         op_class <= CL_NONE;
         wait_cnt <= 8'd0;
         count    <= '0;
      end else begin
         case (state)
            BUSCA: begin
               if (habilita)
                  state <= DECODIFICA;
            end
            DECODIFICA: begin
               if (dec_class == CL_NONE) begin
                  state <= ERRO;
               end else begin
                  state    <= EXECUTA;
                  op_class <= dec_class;
               end
            end
            EXECUTA: begin
               wait_cnt <= 8'd0;
               case (op_class)
                  CL_R, CL_ADDI: state <= ESCRITA;
                  CL_LW, CL_SW:  state <= MEMORIA;
                  CL_BEQ: begin
                     state <= BUSCA;
                     count <= count + CNT_ONE;
                  end
                  default:       state <= ERRO;
               endcase
            end
            MEMORIA: begin
               // a ready arriving on the last allowed cycle still completes
               if (mem_pronto) begin
                  if (op_class == CL_LW) begin
                     state <= ESCRITA;
                  end else if (op_class == CL_SW) begin
                     state <= BUSCA;
                     count <= count + CNT_ONE;
                  end else begin
                     state <= ERRO;
                  end
               end else if (wait_cnt == TIMEOUT_LAST) begin
                  state <= ERRO;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            ESCRITA: begin
               state <= BUSCA;
               count <= count + CNT_ONE;
            end
            ERRO:    state <= ERRO;
            default: state <= ERRO;
         endcase
      end
   end

   // controls are gated by reset so an aborted instruction stops writing at once
   always_comb begin
      PCEsc      = 1'b0;
      IREsc      = 1'b0;
      ULAop      = 2'b00;
      MemParaReg = 1'b0;
      EscMem     = 1'b0;
      LeMem      = 1'b0;
      Desvio     = 1'b0;
      ULAFonte   = 1'b0;
      RegDest    = 1'b0;
      EscReg     = 1'b0;
      if (reset) begin
         case (state)
            BUSCA: begin
               PCEsc = habilita;
               IREsc = habilita;
            end
            EXECUTA: begin
               case (op_class)
                  CL_R:                   ULAop = 2'b10;
                  CL_ADDI, CL_LW, CL_SW:  ULAFonte = 1'b1;
                  CL_BEQ: begin
                     ULAop  = 2'b01;
                     Desvio = 1'b1;
                     PCEsc  = 1'b1;
                  end
                  default: ;
               endcase
            end
            MEMORIA: begin
               ULAFonte = 1'b1;
               LeMem    = (op_class == CL_LW);
               EscMem   = (op_class == CL_SW);
            end
            ESCRITA: begin
               case (op_class)
                  CL_R: begin
                     ULAop   = 2'b10;
                     RegDest = 1'b1;
                     EscReg  = 1'b1;
                  end
                  CL_ADDI: begin
                     ULAFonte = 1'b1;
                     EscReg   = 1'b1;
                  end
                  CL_LW: begin
                     ULAFonte   = 1'b1;
                     MemParaReg = 1'b1;
                     EscReg     = 1'b1;
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   assign estado      = state;
   assign erro        = (state == ERRO);
   assign instr_count = count;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized self-checking bench for multicycle_control
module tb_multicycle_control;

   localparam int MEM_TIMEOUT = 15;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   // {PCEsc, IREsc, ULAop[1:0], MemParaReg, EscMem, LeMem, Desvio, ULAFonte, RegDest, EscReg}
   localparam logic [10:0] C_NONE    = 11'b00_00_0000000;
   localparam logic [10:0] C_FETCH   = 11'b11_00_0000000;
   localparam logic [10:0] C_R_EX    = 11'b00_10_0000000;
   localparam logic [10:0] C_R_WB    = 11'b00_10_0000011;
   localparam logic [10:0] C_I_EX    = 11'b00_00_0000100;
   localparam logic [10:0] C_ADDI_WB = 11'b00_00_0000101;
   localparam logic [10:0] C_LW_MEM  = 11'b00_00_0010100;
   localparam logic [10:0] C_SW_MEM  = 11'b00_00_0100100;
   localparam logic [10:0] C_LW_WB   = 11'b00_00_1000101;
   localparam logic [10:0] C_BEQ_EX  = 11'b10_01_0001000;

   localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_ADDI = 4, K_ILL = 5;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        habilita = 1'b0;
   logic [5:0]  opcode = 6'd0;
   logic        mem_pronto = 1'b0;

   logic        PCEsc, IREsc, MemParaReg, EscMem, LeMem, Desvio, ULAFonte, RegDest, EscReg, erro;
   logic [1:0]  ULAop;
   logic [2:0]  estado;
   logic [15:0] instr_count;

   logic        s_PCEsc, s_IREsc, s_MemParaReg, s_EscMem, s_LeMem, s_Desvio, s_ULAFonte, s_RegDest, s_EscReg, s_erro;
   logic [1:0]  s_ULAop;
   logic [2:0]  s_estado;
   logic [3:0]  s_count;

   logic [10:0] ctl, s_ctl;
   assign ctl   = {PCEsc, IREsc, ULAop, MemParaReg, EscMem, LeMem, Desvio, ULAFonte, RegDest, EscReg};
   assign s_ctl = {s_PCEsc, s_IREsc, s_ULAop, s_MemParaReg, s_EscMem, s_LeMem, s_Desvio, s_ULAFonte, s_RegDest, s_EscReg};

   multicycle_control #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(16)) dut (
      .clock(clock), .reset(reset), .habilita(habilita), .opcode(opcode), .mem_pronto(mem_pronto),
      .PCEsc(PCEsc), .IREsc(IREsc), .ULAop(ULAop), .MemParaReg(MemParaReg), .EscMem(EscMem),
      .LeMem(LeMem), .Desvio(Desvio), .ULAFonte(ULAFonte), .RegDest(RegDest), .EscReg(EscReg),
      .estado(estado), .erro(erro), .instr_count(instr_count)
   );

   multicycle_control #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(4)) u_small (
      .clock(clock), .reset(reset), .habilita(habilita), .opcode(opcode), .mem_pronto(mem_pronto),
      .PCEsc(s_PCEsc), .IREsc(s_IREsc), .ULAop(s_ULAop), .MemParaReg(s_MemParaReg), .EscMem(s_EscMem),
      .LeMem(s_LeMem), .Desvio(s_Desvio), .ULAFonte(s_ULAFonte), .RegDest(s_RegDest), .EscReg(s_EscReg),
      .estado(s_estado), .erro(s_erro), .instr_count(s_count)
   );

   always #5 clock = ~clock;

   int n_chk = 0;
   int n_pass = 0;
   int retired = 0;
   int cyc = 0, obs_le = 0, obs_em = 0, obs_er = 0, obs_mem = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   function automatic logic [5:0] rop();
      return 6'($urandom);
   endfunction

   function automatic logic is_legal(input logic [5:0] op);
      return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_ADDI);
   endfunction

   // one clock cycle: drive inputs just after the edge, compare at the falling edge
   task automatic step(input logic hab, input logic [5:0] op, input logic pr,
                       input logic [2:0] st, input logic [10:0] c, input logic er);
      habilita   = hab;
      opcode     = op;
      mem_pronto = pr;
      @(negedge clock);
      chk("outputs", {estado, ctl, erro, instr_count}, {st, c, er, 16'(retired)});
      chk("small_outputs", {s_estado, s_ctl, s_erro, s_count}, {st, c, er, 4'(retired)});
      chk("mem_reg_exclusive", 64'((int'(EscMem) + int'(LeMem) + int'(EscReg)) > 1), 64'd0);
      cyc++;
      obs_le  += int'(LeMem);
      obs_em  += int'(EscMem);
      obs_er  += int'(EscReg);
      obs_mem += int'(estado == 3'd3);
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b0;
      habilita = 1'b1;
      opcode   = rop();
      retired  = 0;
      @(negedge clock);
      chk("reset_outputs", {estado, ctl, erro, instr_count}, 64'd0);
      chk("reset_small", {s_estado, s_ctl, s_erro, s_count}, 64'd0);
      #1 habilita = 1'b0;
      #1 reset = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic erro_hold(input int n);
      for (int i = 0; i < n; i++) step(1'b1, rop(), rb(), 3'd5, C_NONE, 1'b1);
   endtask

   task automatic run_instr(input int kind, input logic [5:0] op, input int wt, input int idle,
                            input logic abort, output logic trapped);
      logic [10:0] exc, memc, wbc;
      logic        done, pr;
      trapped = 1'b0;
      case (kind)
         K_R:     begin exc = C_R_EX;   memc = C_NONE;   wbc = C_R_WB;    end
         K_LW:    begin exc = C_I_EX;   memc = C_LW_MEM; wbc = C_LW_WB;   end
         K_SW:    begin exc = C_I_EX;   memc = C_SW_MEM; wbc = C_NONE;    end
         K_BEQ:   begin exc = C_BEQ_EX; memc = C_NONE;   wbc = C_NONE;    end
         K_ADDI:  begin exc = C_I_EX;   memc = C_NONE;   wbc = C_ADDI_WB; end
         default: begin exc = C_NONE;   memc = C_NONE;   wbc = C_NONE;    end
      endcase
      for (int i = 0; i < idle; i++) step(1'b0, rop(), rb(), 3'd0, C_NONE, 1'b0);
      step(1'b1, op, rb(), 3'd0, C_FETCH, 1'b0);
      step(rb(), op, rb(), 3'd1, C_NONE, 1'b0);
      if (kind == K_ILL) begin
         erro_hold(3);
         trapped = 1'b1;
         return;
      end
      step(rb(), rop(), rb(), 3'd2, exc, 1'b0);
      if (kind == K_BEQ) begin
         retired++;
         return;
      end
      if (kind == K_LW || kind == K_SW) begin
         done = 1'b0;
         for (int i = 0; i < MEM_TIMEOUT && !done; i++) begin
            pr = (i == wt);
            step(rb(), rop(), pr, 3'd3, memc, 1'b0);
            done = pr;
         end
         if (!done) begin
            erro_hold(3);
            trapped = 1'b1;
            return;
         end
         if (kind == K_SW) begin
            retired++;
            return;
         end
      end
      if (abort) begin
         habilita = 1'b1;
         opcode   = rop();
         #1 chk("escreg_before_abort", EscReg, 1);
         reset = 1'b0;
         #1;
         chk("escreg_after_abort", EscReg, 0);
         chk("estado_after_abort", estado, 0);
         chk("count_after_abort", instr_count, 0);
         do_reset();
         return;
      end
      step(rb(), rop(), rb(), 3'd4, wbc, 1'b0);
      retired++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, le0, em0, er0, m0, kind, wt, idle, r;
      logic tr, ab;
      logic [5:0] op;

      @(posedge clock);
      #1;
      do_reset();

      c0 = cyc;
      run_instr(K_R, OP_R, 0, 0, 1'b0, tr);
      chk("r_cycles", 64'(cyc - c0), 4);
      chk("r_count", instr_count, 1);

      c0 = cyc; le0 = obs_le; em0 = obs_em;
      run_instr(K_LW, OP_LW, 2, 0, 1'b0, tr);
      chk("lw_cycles", 64'(cyc - c0), 7);
      chk("lw_lemem_cycles", 64'(obs_le - le0), 3);
      chk("lw_escmem_cycles", 64'(obs_em - em0), 0);

      c0 = cyc; er0 = obs_er;
      run_instr(K_BEQ, OP_BEQ, 0, 0, 1'b0, tr);
      chk("beq_cycles", 64'(cyc - c0), 3);
      chk("beq_escreg_cycles", 64'(obs_er - er0), 0);

      c0 = cyc;
      run_instr(K_LW, OP_LW, MEM_TIMEOUT - 1, 0, 1'b0, tr);
      chk("lw_last_cycle_ready_cycles", 64'(cyc - c0), 19);
      chk("lw_last_cycle_ready_trap", tr, 0);

      m0 = obs_mem;
      run_instr(K_SW, OP_SW, 99, 0, 1'b0, tr);
      chk("sw_timeout_mem_cycles", 64'(obs_mem - m0), 15);
      chk("sw_timeout_trap", tr, 1);
      chk("sw_timeout_count", instr_count, 4);
      chk("sw_timeout_erro", erro, 1);
      do_reset();

      run_instr(K_ILL, 6'b111111, 0, 0, 1'b0, tr);
      chk("illegal_trap_estado", estado, 5);
      do_reset();

      for (int i = 0; i < 10; i++) step(1'b0, rop(), rb(), 3'd0, C_NONE, 1'b0);
      chk("idle_irsc", IREsc, 0);

      run_instr(K_R, OP_R, 0, 0, 1'b0, tr);
      run_instr(K_ADDI, OP_ADDI, 0, 1, 1'b1, tr);

      for (int i = 0; i < 16; i++) run_instr(K_BEQ, OP_BEQ, 0, 0, 1'b0, tr);
      chk("wrap_small_count", s_count, 0);
      chk("main_count_16", instr_count, 16);

      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 19);
         if (r < 4)       begin kind = K_R;    op = OP_R;    end
         else if (r < 8)  begin kind = K_LW;   op = OP_LW;   end
         else if (r < 12) begin kind = K_SW;   op = OP_SW;   end
         else if (r < 16) begin kind = K_BEQ;  op = OP_BEQ;  end
         else if (r < 19) begin kind = K_ADDI; op = OP_ADDI; end
         else begin
            kind = K_ILL;
            op = rop();
            while (is_legal(op)) op = rop();
         end
         wt   = ($urandom_range(0, 9) == 0) ? MEM_TIMEOUT : $urandom_range(0, MEM_TIMEOUT - 1);
         idle = $urandom_range(0, 2);
         ab   = ($urandom_range(0, 15) == 0);
         run_instr(kind, op, wt, idle, ab, tr);
         if (tr) do_reset();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
